// File: rtl/mascota_pkg.sv
// Shared definitions for the pet controller: state codes, need indices,
// level field width and the per-state decay-enable patterns.
package mascota_pkg;

    localparam int ANCHO_NIVEL = 2;
    localparam int NUM_NEC     = 4;

    localparam int NEC_HAMBRE    = 0;
    localparam int NEC_SUENO     = 1;
    localparam int NEC_DIVERSION = 2;
    localparam int NEC_SALUD     = 3;

    localparam logic [2:0] ESTADO_NORMAL     = 3'd0;
    localparam logic [2:0] ESTADO_ALERTA     = 3'd1;
    localparam logic [2:0] ESTADO_CRITICO    = 3'd2;
    localparam logic [2:0] ESTADO_CELEBRANDO = 3'd3;
    localparam logic [2:0] ESTADO_DORMIDO    = 3'd4;
    localparam logic [2:0] ESTADO_MUERTO     = 3'd5;

    typedef enum logic [2:0] {
        ST_NORMAL     = ESTADO_NORMAL,
        ST_ALERTA     = ESTADO_ALERTA,
        ST_CRITICO    = ESTADO_CRITICO,
        ST_CELEBRANDO = ESTADO_CELEBRANDO,
        ST_DORMIDO    = ESTADO_DORMIDO,
        ST_MUERTO     = ESTADO_MUERTO
    } estado_t;

    // While asleep only the sleep need stops decaying.
    localparam logic [3:0] ACTIVO_TODOS   = 4'b1111;
    localparam logic [3:0] ACTIVO_NINGUNO = 4'b0000;
    localparam logic [3:0] ACTIVO_DORMIDO = 4'b1111 & ~(4'b0001 << NEC_SUENO);

endpackage

// File: rtl/sincronizador_flanco.sv
// Two-flop synchronizer for an asynchronous button followed by a
// rising-edge detector: one clk-wide pulse per press.
module sincronizador_flanco (
    input  logic clk,
    input  logic B_reset,
    input  logic entrada,
    output logic pulso
);

    logic sync1;
    logic sync2;
    logic sync2_d;

    // Synchronizer chain plus the delayed copy used for edge detection.
    always_ff @(posedge clk or negedge B_reset) begin
        if (!B_reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
        end else begin
            sync1   <= entrada;
            sync2   <= sync1;
            sync2_d <= sync2;
        end
    end

    assign pulso = sync2 & ~sync2_d;

endmodule

// File: rtl/maquina_estado_mascota.sv
// Pet-level state machine fed by the four need counters. Produces the
// registered pet state, the index of the lowest need, and the per-need
// decay enables. Owns the death timer and the sleep-button toggle.
//
// state      | meaning
// -----------+-----------------------------------------------
// NORMAL     | all needs at 2 or above, nothing to celebrate
// ALERTA     | lowest need at 1
// CRITICO    | some need at 0, death timer running
// CELEBRANDO | a need was raised recently
// DORMIDO    | asleep; sleep need frozen, leaves on press or min 0
// MUERTO     | terminal; only reset exits
import mascota_pkg::*;

module maquina_estado_mascota #(
    parameter int TIEMPO_MUERTE = 20
) (
    input  logic       clk,
    input  logic       B_reset,
    input  logic [7:0] Niveles,
    input  logic [3:0] senales_5seg,
    input  logic       B_dormir,
    output logic [2:0] Estado,
    output logic [3:0] activo,
    output logic [1:0] Necesidad_Critica,
    output logic       muerto
);

    localparam int CW = $clog2(TIEMPO_MUERTE + 1);
    localparam logic [CW-1:0] CNT_FIN = CW'(TIEMPO_MUERTE - 1);
    localparam logic [CW-1:0] CNT_SAT = CW'(TIEMPO_MUERTE);

    // Returns {argmin, min}; strict less-than keeps the lowest index on ties.
    function automatic logic [3:0] min_argmin(input logic [7:0] niveles);
        logic [1:0] mn;
        logic [1:0] idx;
        logic [1:0] campo;
        mn  = niveles[ANCHO_NIVEL-1:0];
        idx = 2'd0;
        for (int i = 1; i < NUM_NEC; i++) begin
            campo = niveles[i*ANCHO_NIVEL +: ANCHO_NIVEL];
            if (campo < mn) begin
                mn  = campo;
                idx = 2'(i);
            end
        end
        return {idx, mn};
    endfunction

    estado_t       estado_q;
    estado_t       estado_d;
    logic [CW-1:0] cnt_muerte;
    logic [1:0]    nivel_min;
    logic [1:0]    idx_min;
    logic          min_cero;
    logic          dormir_p;

    assign {idx_min, nivel_min} = min_argmin(Niveles);
    assign min_cero = (nivel_min == 2'd0);

    sincronizador_flanco u_sinc_dormir (
        .clk     (clk),
        .B_reset (B_reset),
        .entrada (B_dormir),
        .pulso   (dormir_p)
    );

    // State register and registered lowest-need index.
    always_ff @(posedge clk or negedge B_reset) begin
        if (!B_reset) begin
            estado_q          <= ST_NORMAL;
            Necesidad_Critica <= 2'd0;
        end else begin
            estado_q          <= estado_d;
            Necesidad_Critica <= idx_min;
        end
    end

    // Death timer: counts consecutive edges at min 0, clears otherwise, saturates.
    always_ff @(posedge clk or negedge B_reset) begin
        if (!B_reset) begin
            cnt_muerte <= '0;
        end else if (!min_cero) begin
            cnt_muerte <= '0;
        end else if (estado_q != ST_MUERTO && cnt_muerte != CNT_SAT) begin
            cnt_muerte <= cnt_muerte + CW'(1);
        end
    end

    // Next-state selection in priority order; a press in CRITICO falls through and is lost.
    always_comb begin
        estado_d = estado_q;
        if (estado_q == ST_MUERTO) begin
            estado_d = ST_MUERTO;
        end else if (estado_q > ST_MUERTO) begin
            estado_d = ST_NORMAL;
        end else if (min_cero && cnt_muerte == CNT_FIN) begin
            estado_d = ST_MUERTO;
        end else if (dormir_p && (estado_q == ST_NORMAL || estado_q == ST_ALERTA ||
                                  estado_q == ST_CELEBRANDO)) begin
            estado_d = ST_DORMIDO;
        end else if (dormir_p && estado_q == ST_DORMIDO) begin
            estado_d = ST_NORMAL;
        end else if (estado_q == ST_DORMIDO && !min_cero) begin
            estado_d = ST_DORMIDO;
        end else if (min_cero) begin
            estado_d = ST_CRITICO;
        end else if (|senales_5seg) begin
            estado_d = ST_CELEBRANDO;
        end else if (nivel_min == 2'd1) begin
            estado_d = ST_ALERTA;
        end else begin
            estado_d = ST_NORMAL;
        end
    end

    // Decay enables decoded from the registered state.
    always_comb begin
        activo = ACTIVO_TODOS;
        case (estado_q)
            ST_MUERTO:  activo = ACTIVO_NINGUNO;
            ST_DORMIDO: activo = ACTIVO_DORMIDO;
            default:    activo = ACTIVO_TODOS;
        endcase
    end

    assign Estado = estado_q;
    assign muerto = (estado_q == ST_MUERTO);

endmodule

// File: tb/tb_maquina_estado_mascota.sv
// Bench for maquina_estado_mascota with TIEMPO_MUERTE=5: directed scenarios
// followed by a randomized run, all compared against a behavioural model.
module tb_maquina_estado_mascota;

    localparam int T = 5;

    logic       clk = 1'b0;
    logic       B_reset = 1'b0;
    logic [7:0] Niveles = 8'hFF;
    logic [3:0] senales_5seg = 4'd0;
    logic       B_dormir = 1'b0;
    logic [2:0] Estado;
    logic [3:0] activo;
    logic [1:0] Necesidad_Critica;
    logic       muerto;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int m_est = 0;
    int m_run = 0;   // consecutive edges seen with some need empty
    int m_idx = 0;
    bit hist[3];     // button samples at the previous 1, 2, 3 edges

    maquina_estado_mascota #(.TIEMPO_MUERTE(T)) dut (
        .clk               (clk),
        .B_reset           (B_reset),
        .Niveles           (Niveles),
        .senales_5seg      (senales_5seg),
        .B_dormir          (B_dormir),
        .Estado            (Estado),
        .activo            (activo),
        .Necesidad_Critica (Necesidad_Critica),
        .muerto            (muerto)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lvl(input logic [7:0] n, input int i);
        return int'(n[2*i +: 2]);
    endfunction

    function automatic int exp_activo(input int st);
        if (st == 5) return 0;
        if (st == 4) return 13;
        return 15;
    endfunction

    task automatic model_reset();
        m_est = 0; m_run = 0; m_idx = 0;
        hist[0] = 0; hist[1] = 0; hist[2] = 0;
    endtask

    // One rising edge of the pet's behaviour, from the rules in plain terms.
    task automatic model_edge();
        int mn, ix, nxt;
        bit press;
        mn = 3; ix = 0;
        for (int i = 3; i >= 0; i--)
            if (lvl(Niveles, i) <= mn) begin mn = lvl(Niveles, i); ix = i; end
        press = hist[1] && !hist[2];
        if (m_est == 5)                                 nxt = 5;
        else if (mn == 0 && m_run + 1 >= T)             nxt = 5;
        else if (press && (m_est == 0 || m_est == 1 || m_est == 3)) nxt = 4;
        else if (press && m_est == 4)                   nxt = 0;
        else if (m_est == 4 && mn != 0)                 nxt = 4;
        else if (mn == 0)                               nxt = 2;
        else if (senales_5seg != 0)                     nxt = 3;
        else if (mn == 1)                               nxt = 1;
        else                                            nxt = 0;
        if (mn != 0) m_run = 0;
        else if (m_est != 5) m_run++;
        m_est = nxt;
        m_idx = ix;
        hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = B_dormir;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("estado", {5'd0, Estado}, 8'(m_est));
        chk("necesidad", {6'd0, Necesidad_Critica}, 8'(m_idx));
        chk("activo", {4'd0, activo}, 8'(exp_activo(m_est)));
        chk("muerto", {7'd0, muerto}, 8'(m_est == 5));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Async assert, immediate output check, release on a falling edge.
    task automatic do_reset();
        B_reset = 1'b0;
        #1;
        model_reset();
        chk("rst_estado", {5'd0, Estado}, 8'd0);
        chk("rst_activo", {4'd0, activo}, 8'hF);
        chk("rst_muerto", {7'd0, muerto}, 8'd0);
        chk("rst_necesidad", {6'd0, Necesidad_Critica}, 8'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        B_reset = 1'b1;
    endtask

    initial begin
        model_reset();
        Niveles = 8'hFF; senales_5seg = 4'd0; B_dormir = 1'b0;
        #2;
        do_reset();
        tick();
        chk("reset_hold", {5'd0, Estado}, 8'd0);

        // Alert then critical, with the lowest-need index
        Niveles = 8'b11_11_01_11; tick();
        chk("alerta", {5'd0, Estado}, 8'd1);
        chk("idx_sueno", {6'd0, Necesidad_Critica}, 8'd1);
        Niveles = 8'b11_11_11_00; tick();
        chk("critico", {5'd0, Estado}, 8'd2);
        chk("idx_hambre", {6'd0, Necesidad_Critica}, 8'd0);
        Niveles = 8'hFF; tick();

        // Death after T edges at min 0, then latched
        Niveles = 8'hFC;
        ticks(T - 1);
        chk("pre_muerte", {5'd0, Estado}, 8'd2);
        tick();
        chk("muerte", {5'd0, Estado}, 8'd5);
        chk("muerte_activo", {4'd0, activo}, 8'h0);
        chk("muerte_flag", {7'd0, muerto}, 8'd1);
        Niveles = 8'hFF; ticks(3);
        chk("muerte_latch", {5'd0, Estado}, 8'd5);

        // A single min=1 cycle restarts the full count
        do_reset();
        Niveles = 8'hFC; ticks(2);
        Niveles = 8'hFD; tick();
        Niveles = 8'hFC; ticks(T - 1);
        chk("glitch_vivo", {5'd0, Estado}, 8'd2);
        tick();
        chk("glitch_muerte", {5'd0, Estado}, 8'd5);

        // Sleep toggle: one toggle per press, held or not
        do_reset();
        Niveles = 8'hFF; ticks(2);
        B_dormir = 1'b1; ticks(2);
        chk("dormir_lat", {5'd0, Estado}, 8'd0);
        tick();
        chk("dormido", {5'd0, Estado}, 8'd4);
        chk("dormido_activo", {4'd0, activo}, 8'hD);
        tick();
        B_dormir = 1'b0; ticks(4);
        chk("dormido_uno", {5'd0, Estado}, 8'd4);
        B_dormir = 1'b1; ticks(4);
        B_dormir = 1'b0; ticks(2);
        chk("despierto", {5'd0, Estado}, 8'd0);

        // Press during CRITICO is dropped
        Niveles = 8'hFC; B_dormir = 1'b1; ticks(3);
        chk("critico_press", {5'd0, Estado}, 8'd2);
        Niveles = 8'hFF; ticks(2);
        chk("press_perdido", {5'd0, Estado}, 8'd0);
        B_dormir = 1'b0; ticks(3);

        // Celebration, and CRITICO outranks it
        senales_5seg = 4'b0100; ticks(3);
        chk("celebrando", {5'd0, Estado}, 8'd3);
        senales_5seg = 4'b0000; tick();
        chk("fin_celebra", {5'd0, Estado}, 8'd0);
        senales_5seg = 4'b0100; Niveles = 8'hFC; tick();
        chk("celebra_critico", {5'd0, Estado}, 8'd2);
        senales_5seg = 4'b0000; Niveles = 8'hFF; tick();

        // Reset at count 3 of 5, then a full count is needed
        Niveles = 8'hFC; ticks(3);
        @(negedge clk);
        do_reset();
        ticks(T - 1);
        chk("rst_cuenta_viva", {5'd0, Estado}, 8'd2);
        tick();
        chk("rst_cuenta_muerte", {5'd0, Estado}, 8'd5);

        // Randomized run against the model
        do_reset();
        Niveles = 8'hFF;
        for (int k = 0; k < 600; k++) begin
            logic [7:0] n;
            for (int i = 0; i < 4; i++)
                n[2*i +: 2] = ($urandom_range(0, 9) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            Niveles = n;
            senales_5seg = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            if ($urandom_range(0, 4) == 0) B_dormir = ~B_dormir;
            tick();
            if (m_est == 5 && $urandom_range(0, 3) == 0) begin
                @(negedge clk);
                do_reset();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/maquina_estado_mascota.md
# maquina_estado_mascota

Pet-level state machine directly downstream of the four need-level counters (hunger, sleep, fun, health). It consumes their 2-bit levels and "recently fed" flags and produces a single registered pet state for the display stage. It also drives back the per-need `activo` enables that freeze or allow each counter's decay. It owns the death timer and the sleep-button toggle.

## Interface
- `TIEMPO_MUERTE`, default 20: consecutive clk cycles with any need at level 0 before entering MUERTO; must be ≥1.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `B_reset`  in  1  reset, asynchronous, active-low.
- `Niveles`  in  8  packed need levels: [1:0] hunger (idx 0), [3:2] sleep (idx 1), [5:4] fun (idx 2), [7:6] health (idx 3); 0 = empty, 3 = full.
- `senales_5seg`  in  4  per-need "recently raised" flags, same index order.
- `B_dormir`  in  1  raw sleep button, asynchronous to clk, active-high.
- `Estado`  out  3  registered pet state.
- `activo`  out  4  per-need decay enable, same index order.
- `Necesidad_Critica`  out  2  registered index of the lowest need.
- `muerto`  out  1  high iff `Estado` == MUERTO.

## Operation
- State encodings: NORMAL=0, ALERTA=1, CRITICO=2, CELEBRANDO=3, DORMIDO=4, MUERTO=5; codes 6–7 are illegal and recover to NORMAL on the next edge.
- `min` is the minimum of the four 2-bit levels, computed combinationally.
- `Necesidad_Critica` is the index of `min`; on ties the lowest index wins.
- Sleep request:
  - `B_dormir` passes a 2-flop synchronizer, then a rising-edge detector.
  - The resulting pulse `dormir_p` is high for exactly one cycle per press.
- Death counter `cnt_muerte`, width $clog2(TIEMPO_MUERTE+1):
  - Increments on each edge where `min`==0 and the state is not MUERTO.
  - Clears to 0 on any edge where `min`≠0.
  - Saturates; it never wraps.
- Next-state priority, highest first:
  1. MUERTO stays MUERTO; only reset exits.
  2. `min`==0 and `cnt_muerte`==TIEMPO_MUERTE-1 → MUERTO.
  3. `dormir_p` and state ∈ {NORMAL, ALERTA, CELEBRANDO} → DORMIDO.
  4. `dormir_p` and state == DORMIDO → NORMAL.
  5. DORMIDO with `min`≠0 and no `dormir_p` → stays DORMIDO.
  6. `min`==0 → CRITICO. This also forces DORMIDO out.
  7. Any `senales_5seg` bit high → CELEBRANDO.
  8. `min`==1 → ALERTA.
  9. Otherwise → NORMAL.
- `dormir_p` while in CRITICO is ignored and dropped, not queued.
- `activo` is decoded combinationally from the registered state:
  - MUERTO → 4'b0000.
  - DORMIDO → 4'b1101 (sleep need frozen).
  - All other states → 4'b1111.
- `muerto` is a combinational decode of `Estado`.

## Timing
- Reset values:
  - `Estado`=NORMAL, `activo`=4'b1111, `muerto`=0, `Necesidad_Critica`=0.
  - `cnt_muerte`=0; synchronizer and edge registers = 0.
- Reset assertion takes effect immediately (asynchronous). Release is sampled at the next clk edge.
- Level/flag input to `Estado`: 1 cycle latency. Inputs sampled at edge k appear on `Estado` after edge k.
- `Necesidad_Critica` has the same 1-cycle latency.
- `B_dormir` to `Estado`:
  - Rises before edge 1; sync1 captures at edge 1 and sync2 at edge 2.
  - `dormir_p` is high between edges 2 and 3; `Estado` changes at edge 3.
- Button held high produces one toggle only; releasing it produces nothing.
- Death timing: `min` held at 0 from edge 1 onward gives `Estado`=MUERTO after edge TIEMPO_MUERTE.
  - With TIEMPO_MUERTE=1, MUERTO is entered on the first such edge.
- `min` returning to ≥1 for one cycle restarts the full death count.
- `activo` follows `Estado` combinationally. Counters upstream see the new enable one cycle after the state change.
- Reset mid-count or in MUERTO returns every register to its reset value.

## Structure
- Shared package `mascota_pkg` holds:
  - State encodings `ESTADO_*` (3-bit localparams).
  - Need indices `NEC_HAMBRE`=0, `NEC_SUENO`=1, `NEC_DIVERSION`=2, `NEC_SALUD`=3.
  - Field width `ANCHO_NIVEL`=2.
- Sub-module `sincronizador_flanco`: 2-flop synchronizer plus rising-edge pulse, same clk and B_reset. Reused later for the feed/play buttons.
- Min/argmin is a combinational function inside this block.

## Test plan
- Reset with `Niveles`=8'hFF, flags 0: `Estado`=0, `activo`=1111, `muerto`=0; after one edge `Estado` stays 0.
- Set `Niveles`=8'b11_11_01_11, then 8'b11_11_11_00:
  - First value → `Estado`=1, `Necesidad_Critica`=1.
  - Second value → `Estado`=2, `Necesidad_Critica`=0.
- TIEMPO_MUERTE=5 with hunger held at 0: `Estado`=2 for edges 1–4, `Estado`=5 after edge 5, `activo`=0000, `muerto`=1.
  - Later raising `Niveles` to FF keeps `Estado`=5.
  - A single-cycle `min`=1 glitch at edge 3 restarts the count.
- `Niveles`=FF, `B_dormir` pulsed for 4 cycles:
  - `Estado`=4 after edge 3, `activo`=1101; exactly one toggle.
  - A second press returns to 0.
  - A press during CRITICO leaves the state unchanged.
- `Niveles`=FF and `senales_5seg`=0100 for 3 cycles: `Estado`=3 for 3 cycles, then 0.
  - Same flags with hunger at 0 → `Estado`=2.
- `B_reset` pulled low mid death count (count 3 of 5): all outputs return immediately to reset values. After release, a full 5 cycles at `min`=0 are needed to reach MUERTO.
